// File: rtl/ibm_pf.sv
// Input buffer manager: filters packets by type and free-buffer count, forwards
// accepted packets to data_cache and emits delayed TSN metadata with the buffer ID.
module ibm_pf #(
    parameter int          DATA_W       = 134,
    parameter int          TYPE_LSB     = 80,
    parameter logic [15:0] ACCEPT_MASK  = 16'hFFE2,
    parameter bit          ACCEPT_HIGH  = 1'b1,
    parameter int          MIN_FREE_BUF = 1,
    parameter int          MD_DELAY     = 2,
    parameter int          CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_ibm_data,
    input  logic              in_ibm_data_wr,
    input  logic              in_ibm_valid,
    input  logic              in_ibm_valid_wr,
    input  logic [23:0]       in_ibm_tsn_md,
    input  logic              in_ibm_tsn_md_wr,
    input  logic [7:0]        in_ibm_ID,
    input  logic [4:0]        in_ibm_ID_count,
    input  logic              in_cnt_clr,
    output logic [4:0]        out_ibm_bufm_ID,
    output logic [DATA_W-1:0] out_ibm_data,
    output logic              out_ibm_data_wr,
    output logic              out_ibm_valid,
    output logic              out_ibm_valid_wr,
    output logic [23:0]       out_ibm_md,
    output logic              out_ibm_md_wr,
    output logic [CNT_W-1:0]  out_pkt_in_cnt,
    output logic [CNT_W-1:0]  out_pkt_fwd_cnt,
    output logic [CNT_W-1:0]  out_drop_type_cnt,
    output logic [CNT_W-1:0]  out_drop_buf_cnt,
    output logic [CNT_W-1:0]  out_err_cnt
);
    typedef enum logic [1:0] {IDLE, TRANS, DISC} state_t;
    localparam logic [1:0] TAG_HEAD = 2'b01;
    localparam logic [1:0] TAG_TAIL = 2'b10;
    localparam int C_IN = 0, C_FWD = 1, C_DT = 2, C_DB = 3, C_ERR = 4;

    state_t state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic data_wr_q, data_wr_d, valid_q, valid_d, valid_wr_q, valid_wr_d;
    logic [15:0] md_reg_q, md_reg_d, pkt_md_q, pkt_md_d;
    logic [MD_DELAY-1:0] dl_wr_q, dl_wr_d;
    logic [MD_DELAY-1:0][15:0] dl_md_q, dl_md_d;
    logic [23:0] md_q, md_d;
    logic md_wr_q, md_wr_d;
    logic [4:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0] inc;
    logic push;

    logic [1:0] tag;
    logic [7:0] pkt_type;
    logic is_head, is_tail, type_ok, buf_ok;
    logic unused_in;

    assign tag      = in_ibm_data[DATA_W-1 -: 2];
    assign pkt_type = in_ibm_data[TYPE_LSB +: 8];
    assign is_head  = in_ibm_data_wr && (tag == TAG_HEAD);
    assign is_tail  = in_ibm_data_wr && (tag == TAG_TAIL);
    assign type_ok  = (pkt_type < 8'd16) ? ACCEPT_MASK[pkt_type[3:0]] : ACCEPT_HIGH;
    assign buf_ok   = ({27'd0, in_ibm_ID_count} >= 32'(MIN_FREE_BUF));
    assign md_reg_d = in_ibm_tsn_md_wr ? in_ibm_tsn_md[23:8] : md_reg_q;
    assign unused_in = ^{in_ibm_valid_wr, in_ibm_tsn_md[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (is_head) state_d = (type_ok && buf_ok) ? TRANS : DISC;
            TRANS:   if (is_head || is_tail) state_d = IDLE;
            DISC:    if (is_tail) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d     = '0;
        data_wr_d  = 1'b0;
        valid_d    = 1'b0;
        valid_wr_d = 1'b0;
        push       = 1'b0;
        inc        = '0;
        pkt_md_d   = pkt_md_q;
        case (state_q)
            IDLE: if (is_head) begin
                inc[C_IN] = 1'b1;
                if (type_ok && buf_ok) begin
                    data_d    = in_ibm_data;
                    data_wr_d = 1'b1;
                    pkt_md_d  = md_reg_d;
                end else if (!type_ok) begin
                    inc[C_DT] = 1'b1;
                end else begin
                    inc[C_DB] = 1'b1;
                end
            end
            TRANS: if (in_ibm_data_wr) begin
                data_d    = in_ibm_data;
                data_wr_d = 1'b1;
                if (is_tail) begin
                    valid_d    = in_ibm_valid;
                    valid_wr_d = 1'b1;
                    inc[C_FWD] = 1'b1;
                    push       = 1'b1;
                end else if (is_head) begin
                    // close the truncated packet as an invalid tail; the new head is lost
                    data_d[DATA_W-1 -: 2] = TAG_TAIL;
                    valid_wr_d = 1'b1;
                    inc[C_ERR] = 1'b1;
                end
            end
            DISC: if (is_head) inc[C_ERR] = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        dl_wr_d    = '0;
        dl_md_d    = '0;
        dl_wr_d[0] = push;
        dl_md_d[0] = pkt_md_q;
        for (int i = 1; i < MD_DELAY; i++) begin
            dl_wr_d[i] = dl_wr_q[i-1];
            dl_md_d[i] = dl_md_q[i-1];
        end
        md_wr_d = dl_wr_q[MD_DELAY-1];
        md_d    = md_wr_d ? {dl_md_q[MD_DELAY-1], in_ibm_ID} : md_q;
    end

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 5; i++) begin
            if (in_cnt_clr)                   cnt_d[i] = '0;
            else if (inc[i] && !(&cnt_q[i]))  cnt_d[i] = cnt_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            data_wr_q  <= 1'b0;
            valid_q    <= 1'b0;
            valid_wr_q <= 1'b0;
            md_reg_q   <= '0;
            pkt_md_q   <= '0;
            dl_wr_q    <= '0;
            dl_md_q    <= '0;
            md_q       <= '0;
            md_wr_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            data_q     <= data_d;
            data_wr_q  <= data_wr_d;
            valid_q    <= valid_d;
            valid_wr_q <= valid_wr_d;
            md_reg_q   <= md_reg_d;
            pkt_md_q   <= pkt_md_d;
            dl_wr_q    <= dl_wr_d;
            dl_md_q    <= dl_md_d;
            md_q       <= md_d;
            md_wr_q    <= md_wr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_ibm_bufm_ID   = in_ibm_ID_count;
    assign out_ibm_data      = data_q;
    assign out_ibm_data_wr   = data_wr_q;
    assign out_ibm_valid     = valid_q;
    assign out_ibm_valid_wr  = valid_wr_q;
    assign out_ibm_md        = md_q;
    assign out_ibm_md_wr     = md_wr_q;
    assign out_pkt_in_cnt    = cnt_q[C_IN];
    assign out_pkt_fwd_cnt   = cnt_q[C_FWD];
    assign out_drop_type_cnt = cnt_q[C_DT];
    assign out_drop_buf_cnt  = cnt_q[C_DB];
    assign out_err_cnt       = cnt_q[C_ERR];
endmodule

// File: tb/tb_ibm_pf.sv
// Bench for ibm_pf: directed scenarios plus random packet traffic, compared
// every cycle against a word-level behavioural model of the filtering rules.
module tb_ibm_pf;
    localparam int DW = 134, CW = 4, MDD = 2;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [DW-1:0] in_ibm_data = '0;
    logic in_ibm_data_wr = 0, in_ibm_valid = 0, in_ibm_valid_wr = 0;
    logic [23:0] in_ibm_tsn_md = '0;
    logic in_ibm_tsn_md_wr = 0, in_cnt_clr = 0;
    logic [7:0] in_ibm_ID = '0;
    logic [4:0] in_ibm_ID_count = 5'd3;
    logic [4:0] out_ibm_bufm_ID;
    logic [DW-1:0] out_ibm_data;
    logic out_ibm_data_wr, out_ibm_valid, out_ibm_valid_wr, out_ibm_md_wr;
    logic [23:0] out_ibm_md;
    logic [CW-1:0] c_in, c_fwd, c_dt, c_db, c_err;

    always #5 clk = ~clk;

    ibm_pf #(.DATA_W(DW), .TYPE_LSB(80), .ACCEPT_MASK(16'hFFE2), .ACCEPT_HIGH(1'b1),
             .MIN_FREE_BUF(1), .MD_DELAY(MDD), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_ibm_data(in_ibm_data), .in_ibm_data_wr(in_ibm_data_wr),
        .in_ibm_valid(in_ibm_valid), .in_ibm_valid_wr(in_ibm_valid_wr),
        .in_ibm_tsn_md(in_ibm_tsn_md), .in_ibm_tsn_md_wr(in_ibm_tsn_md_wr),
        .in_ibm_ID(in_ibm_ID), .in_ibm_ID_count(in_ibm_ID_count), .in_cnt_clr(in_cnt_clr),
        .out_ibm_bufm_ID(out_ibm_bufm_ID), .out_ibm_data(out_ibm_data),
        .out_ibm_data_wr(out_ibm_data_wr), .out_ibm_valid(out_ibm_valid),
        .out_ibm_valid_wr(out_ibm_valid_wr), .out_ibm_md(out_ibm_md),
        .out_ibm_md_wr(out_ibm_md_wr), .out_pkt_in_cnt(c_in), .out_pkt_fwd_cnt(c_fwd),
        .out_drop_type_cnt(c_dt), .out_drop_buf_cnt(c_db), .out_err_cnt(c_err));

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // reference model state: packet mode, metadata binding, counters, pending md events
    typedef struct { int due; logic [15:0] md; } md_ev_t;
    md_ev_t mq[$];
    int mode;                        // 0 waiting for head, 1 forwarding, 2 discarding
    int cyc = 0;
    int m_cnt[5];
    logic [15:0] m_mdreg, m_pktmd;
    logic [23:0] m_omd;
    logic [DW-1:0] e_data;
    logic e_dwr, e_valid, e_vwr, e_mdwr;
    logic [15:0] amask = 16'hFFE2;
    bit rnd_mode = 0;

    function automatic bit type_pass(input logic [7:0] t);
        return (t < 8'd16) ? amask[t[3:0]] : 1'b1;
    endfunction

    task automatic model_clear();
        mq.delete();
        mode = 0; m_mdreg = '0; m_pktmd = '0; m_omd = '0;
        for (int i = 0; i < 5; i++) m_cnt[i] = 0;
        e_data = '0; e_dwr = 0; e_valid = 0; e_vwr = 0; e_mdwr = 0;
    endtask

    task automatic check_all();
        chk("data",  {out_ibm_data_wr, out_ibm_data}, {e_dwr, e_data});
        chk("valid", {out_ibm_valid, out_ibm_valid_wr}, {e_valid, e_vwr});
        chk("md",    {out_ibm_md_wr, out_ibm_md}, {e_mdwr, m_omd});
        chk("cnt",   {c_in, c_fwd, c_dt, c_db, c_err},
             {4'(m_cnt[0]), 4'(m_cnt[1]), 4'(m_cnt[2]), 4'(m_cnt[3]), 4'(m_cnt[4])});
        chk("bufm",  out_ibm_bufm_ID, in_ibm_ID_count);
    endtask

    // apply the rules to the current inputs, then clock and compare
    task automatic step();
        logic [15:0] md_cur;
        logic [1:0] tg;
        logic [7:0] ty;
        int inc[5];
        md_cur = in_ibm_tsn_md_wr ? in_ibm_tsn_md[23:8] : m_mdreg;
        tg = in_ibm_data[DW-1 -: 2];
        ty = in_ibm_data[80 +: 8];
        e_data = '0; e_dwr = 0; e_valid = 0; e_vwr = 0; e_mdwr = 0;
        for (int i = 0; i < 5; i++) inc[i] = 0;
        if (in_ibm_data_wr) begin
            if (mode == 0) begin
                if (tg == 2'b01) begin
                    inc[0] = 1;
                    if (!type_pass(ty)) begin inc[2] = 1; mode = 2; end
                    else if (in_ibm_ID_count < 5'd1) begin inc[3] = 1; mode = 2; end
                    else begin e_data = in_ibm_data; e_dwr = 1; m_pktmd = md_cur; mode = 1; end
                end
            end else if (mode == 1) begin
                e_dwr = 1; e_data = in_ibm_data;
                if (tg == 2'b10) begin
                    e_valid = in_ibm_valid; e_vwr = 1; inc[1] = 1;
                    mq.push_back('{due: cyc + 1 + MDD, md: m_pktmd});
                    mode = 0;
                end else if (tg == 2'b01) begin
                    e_data[DW-1 -: 2] = 2'b10; e_vwr = 1; inc[4] = 1; mode = 0;
                end
            end else begin
                if (tg == 2'b10) mode = 0;
                else if (tg == 2'b01) inc[4] = 1;
            end
        end
        if (mq.size() > 0 && mq[0].due == cyc + 1) begin
            e_mdwr = 1; m_omd = {mq[0].md, in_ibm_ID};
            void'(mq.pop_front());
        end
        m_mdreg = md_cur;
        for (int i = 0; i < 5; i++)
            m_cnt[i] = in_cnt_clr ? 0 : ((m_cnt[i] + inc[i] > 15) ? 15 : m_cnt[i] + inc[i]);
        @(posedge clk);
        cyc++;
        #1;
        check_all();
    endtask

    task automatic side_rand();
        if (rnd_mode) begin
            in_ibm_tsn_md_wr = ($urandom_range(0, 3) == 0);
            in_ibm_tsn_md    = 24'($urandom);
            in_ibm_ID        = 8'($urandom);
            in_ibm_ID_count  = 5'($urandom_range(0, 3));
            in_cnt_clr       = ($urandom_range(0, 49) == 0);
        end
    endtask

    function automatic logic [DW-1:0] mkw(input logic [1:0] tg, input logic [7:0] t);
        logic [159:0] r;
        logic [DW-1:0] w;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        w = r[DW-1:0];
        w[DW-1 -: 2] = tg;
        w[80 +: 8] = t;
        return w;
    endfunction

    task automatic word(input logic [1:0] tg, input logic [7:0] t, input logic v);
        side_rand();
        in_ibm_data = mkw(tg, t); in_ibm_data_wr = 1; in_ibm_valid = v;
        step();
        in_ibm_data_wr = 0; in_ibm_tsn_md_wr = 0; in_cnt_clr = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            side_rand();
            in_ibm_data = mkw(2'($urandom), 8'($urandom)); in_ibm_data_wr = 0;
            step();
        end
        in_ibm_tsn_md_wr = 0; in_cnt_clr = 0;
    endtask

    task automatic pkt(input logic [7:0] t, input int len, input logic v);
        word(2'b01, t, v);
        for (int i = 0; i < len - 2; i++) word(2'b11, t, v);
        if (len > 1) word(2'b10, t, v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("rst", {out_ibm_data_wr, out_ibm_data, out_ibm_valid, out_ibm_valid_wr,
                    out_ibm_md_wr, out_ibm_md, c_in, c_fwd, c_dt, c_db, c_err}, '0);
        model_clear();
        #1 rst_n = 1;
    endtask

    initial begin
        logic [7:0] types [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 15, 16, 200};
        model_clear();
        #2;
        chk("rst0", {out_ibm_data_wr, out_ibm_data, out_ibm_valid, out_ibm_valid_wr,
                     out_ibm_md_wr, out_ibm_md, c_in, c_fwd, c_dt, c_db, c_err}, '0);
        #1 rst_n = 1;

        // type 1, 4 words, metadata strobed with the head
        in_ibm_ID = 8'h17; in_ibm_ID_count = 5'd3;
        in_ibm_tsn_md = 24'hABCD00; in_ibm_tsn_md_wr = 1;
        pkt(8'd1, 4, 1'b1);
        idle(2);
        chk("t1_md", {out_ibm_md_wr, out_ibm_md}, {1'b1, 24'hABCD17});
        chk("t1_fwd", c_fwd, 4'd1);
        idle(1);

        // type 3 dropped, type 6 forwarded
        pkt(8'd3, 3, 1'b1);
        chk("t2_drop_type", c_dt, 4'd1);
        pkt(8'd6, 2, 1'b0);
        idle(3);

        // no free buffer
        in_ibm_ID_count = 5'd0;
        pkt(8'd5, 3, 1'b1);
        chk("t3_drop_buf", c_db, 4'd1);
        in_ibm_ID_count = 5'd3;
        idle(3);

        // head, body, head without tail
        word(2'b01, 8'd1, 1'b1);
        word(2'b11, 8'd1, 1'b1);
        word(2'b01, 8'd1, 1'b1);
        chk("t4_trunc", {out_ibm_data[DW-1 -: 2], out_ibm_valid, out_ibm_valid_wr}, 4'b1001);
        chk("t4_err", c_err, 4'd1);
        idle(3);

        // back-to-back 2-word packets, then saturate and clear alongside a head
        for (int i = 0; i < 14; i++) pkt(8'd1, 2, 1'b1);
        chk("t5_sat", c_in, 4'hF);
        in_cnt_clr = 1;
        word(2'b01, 8'd1, 1'b1);
        chk("t5_clr", c_in, 4'd0);
        word(2'b10, 8'd1, 1'b1);
        idle(3);

        // reset in the middle of a packet; the late tail must vanish
        word(2'b01, 8'd7, 1'b1);
        word(2'b11, 8'd7, 1'b1);
        do_reset();
        word(2'b10, 8'd7, 1'b1);
        idle(3);

        rnd_mode = 1;
        for (int p = 0; p < 300; p++) begin
            int len;
            len = $urandom_range(1, 5);
            if ($urandom_range(0, 19) == 0) word(2'($urandom), 8'($urandom), 1'($urandom));
            word(2'b01, types[$urandom_range(0, 10)], 1'b0);
            for (int i = 0; i < len - 2; i++) begin
                word(2'b11, 8'($urandom), 1'($urandom));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            if (len > 1 && $urandom_range(0, 9) != 0) word(2'b10, 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 2));
        end
        rnd_mode = 0;
        idle(MDD + 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ibm_pf.md
# ibm_pf

Parametrised successor of the input buffer manager: receives packets from the port/CPU path, filters them by a configurable type mask and by free-buffer availability, forwards accepted packets to data_cache, and emits TSN metadata carrying the allocated buffer ID to eos. Adds run-time drop/forward statistics, protocol-error recovery and a configurable metadata-to-ID alignment delay.

## Interface
- DATA_W, 134: packet word width; [DATA_W-1:DATA_W-2] is the word tag (01 head, 11 body, 10 tail).
- TYPE_LSB, 80: LSB of the 8-bit packet-type field in the head word.
- ACCEPT_MASK, 16'hFFE2: bit t=1 accepts type t for t<16.
- ACCEPT_HIGH, 1: 1 accepts all types ≥16.
- MIN_FREE_BUF, 1: minimum in_ibm_ID_count required to accept a packet.
- MD_DELAY, 2: cycles from tail output to out_ibm_md_wr (range 1..8).
- CNT_W, 32: statistics counter width.
- clk  in  1  clock (single clock domain).
- rst_n  in  1  asynchronous, active-low reset.
- in_ibm_data  in  DATA_W  packet word; in_ibm_data_wr  in  1  word strobe.
- in_ibm_valid  in  1  packet-valid flag, meaningful on tail word; in_ibm_valid_wr  in  1  unused strobe (kept for port compatibility).
- in_ibm_tsn_md  in  24  TSN metadata; in_ibm_tsn_md_wr  in  1  metadata strobe.
- in_ibm_ID  in  8  buffer ID from bufm; in_ibm_ID_count  in  5  free-buffer count.
- in_cnt_clr  in  1  synchronous clear of all statistics counters.
- out_ibm_bufm_ID  out  5  combinational copy of in_ibm_ID_count.
- out_ibm_data  out  DATA_W; out_ibm_data_wr  out  1; out_ibm_valid  out  1; out_ibm_valid_wr  out  1  forwarded packet to data_cache.
- out_ibm_md  out  24  {tsn_md[23:8], buffer ID}; out_ibm_md_wr  out  1.
- out_pkt_in_cnt, out_pkt_fwd_cnt, out_drop_type_cnt, out_drop_buf_cnt, out_err_cnt  out  CNT_W each.

## Operation
- States: IDLE, TRANS, DISC. All outputs and counters reset to 0, state to IDLE.
- Words with in_ibm_data_wr=0 are ignored in every state.
- IDLE: head word (tag 01) increments pkt_in_cnt. Accept when type passes mask (t<16: ACCEPT_MASK[t]; t≥16: ACCEPT_HIGH) AND in_ibm_ID_count ≥ MIN_FREE_BUF → forward head, latch md_reg[23:8], go TRANS. Type fail → drop_type_cnt++, DISC. Type pass but buffer fail → drop_buf_cnt++, DISC. Non-head words in IDLE ignored.
- md_reg: updated by every in_ibm_tsn_md_wr; the value present at the head cycle (including a strobe on that same cycle) is the one bound to the packet.
- TRANS: forward every word. Tail (10): out_ibm_valid=in_ibm_valid, out_ibm_valid_wr=1, pkt_fwd_cnt++, push md_reg[23:8] into delay line, go IDLE. Head (01) in TRANS: forward that word with tag forced to 10, out_ibm_valid=0, out_ibm_valid_wr=1, err_cnt++, go IDLE (the new packet is lost, no md pushed).
- DISC: output nothing; tail → IDLE; head → err_cnt++, stay DISC.
- Delay line: MD_DELAY-stage shift of {wr,md[23:8]}; at exit out_ibm_md={md,in_ibm_ID sampled that cycle}, out_ibm_md_wr=1 for one cycle. out_ibm_md holds its last value otherwise.
- Counters saturate at all-ones; in_cnt_clr zeros all five next cycle and wins over a simultaneous increment.

## Timing
- Data path: registered, 1-cycle latency; out_ibm_data_wr=0 cycles carry data 0.
- out_ibm_valid/out_ibm_valid_wr asserted only on the tail output cycle.
- out_ibm_md_wr rises exactly MD_DELAY cycles after out_ibm_valid_wr of a well-formed tail; back-to-back 2-word packets yield md_wr pulses 2 cycles apart.
- Reset mid-packet: outputs drop to 0 immediately; delay line cleared; a tail arriving after reset is ignored.

## Test plan
- Type 1, 4-word packet, valid=1, ID_count=3, md=0xABCD00, ID=0x17 → 4 words out 1 cycle late, valid_wr on word 4, md_wr 2 cycles later with out_ibm_md=0xABCD17; fwd_cnt=1.
- Type 3 packet → no output, drop_type_cnt=1, next type 6 packet forwarded normally.
- Type 5, ID_count=0 → no output, drop_buf_cnt=1, no md_wr.
- Head, body, then new head without tail → third output word tagged 10, valid=0, valid_wr=1; err_cnt=1; no md_wr.
- Counter at all-ones plus pkt, then in_cnt_clr concurrent with head → counter stays saturated, then reads 0.
- Assert rst_n low during TRANS body → all outputs 0 same edge; subsequent tail produces no output.
